// File: rtl/motor_pwm_timer.sv
// Motor PWM generator with soft duty ramping and a three-preset auto-off countdown timer.
// Consumes the 3-bit speed level and reports timer expiry back to the speed FSM.
module motor_pwm_timer #(
    parameter int TICK_DIV     = 1000,
    parameter int RAMP_PERIODS = 4,
    parameter int RAMP_STEP    = 5,
    parameter int SEC_CYCLES   = 100_000_000,
    parameter int T1_SEC       = 60,
    parameter int T2_SEC       = 180,
    parameter int T3_SEC       = 300
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [2:0] i_speed_state,
    input  logic       i_timer_btn,
    output logic       o_pwm,
    output logic [6:0] o_duty,
    output logic [1:0] o_timer_state,
    output logic [8:0] o_remain_sec,
    output logic       o_timer_expired
);

    localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int RAMP_W  = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;
    localparam int SEC_W   = (SEC_CYCLES > 1) ? $clog2(SEC_CYCLES) : 1;

    typedef enum logic [1:0] {
        T_OFF = 2'b00,
        T_1   = 2'b01,
        T_2   = 2'b10,
        T_3   = 2'b11
    } timer_state_t;

    logic [PRESC_W-1:0] presc_r;
    logic [6:0]         pwm_cnt_r;
    logic [RAMP_W-1:0]  ramp_cnt_r;
    logic [6:0]         cur_duty_r;
    logic               pwm_r;
    logic               btn_prev_r;
    timer_state_t       tstate_r;
    logic [8:0]         remain_r;
    logic               expired_r;
    logic [SEC_W-1:0]   sec_cnt_r;

    logic       tick_s;
    logic       boundary_s;
    logic [6:0] target_s;
    logic [6:0] next_duty_s;
    logic       press_s;
    logic       sec_wrap_s;

    function automatic logic [6:0] level_to_duty(input logic [2:0] lvl);
        case (lvl)
            3'd1:    return 7'd25;
            3'd2:    return 7'd50;
            3'd3:    return 7'd75;
            3'd4:    return 7'd100;
            default: return 7'd0;
        endcase
    endfunction

    assign tick_s     = (presc_r == PRESC_W'(TICK_DIV - 1));
    assign boundary_s = tick_s && (pwm_cnt_r == 7'd99);
    assign target_s   = level_to_duty(i_speed_state);
    assign press_s    = i_timer_btn && !btn_prev_r;
    assign sec_wrap_s = (tstate_r != T_OFF) && (sec_cnt_r == SEC_W'(SEC_CYCLES - 1));

    // One ramp step toward target, clamped so it never overshoots
    always_comb begin
        next_duty_s = cur_duty_r;
        if (target_s > cur_duty_r) begin
            if ((target_s - cur_duty_r) > 7'(RAMP_STEP)) begin
                next_duty_s = cur_duty_r + 7'(RAMP_STEP);
            end else begin
                next_duty_s = target_s;
            end
        end else if (target_s < cur_duty_r) begin
            if ((cur_duty_r - target_s) > 7'(RAMP_STEP)) begin
                next_duty_s = cur_duty_r - 7'(RAMP_STEP);
            end else begin
                next_duty_s = target_s;
            end
        end else begin
            next_duty_s = cur_duty_r;
        end
    end

    // Prescaler, PWM counter and registered PWM comparator
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            presc_r   <= '0;
            pwm_cnt_r <= 7'd0;
            pwm_r     <= 1'b0;
        end else begin
            presc_r <= tick_s ? '0 : presc_r + PRESC_W'(1);
            if (tick_s) begin
                pwm_cnt_r <= (pwm_cnt_r == 7'd99) ? 7'd0 : pwm_cnt_r + 7'd1;
            end
            pwm_r <= (pwm_cnt_r < cur_duty_r);
        end
    end

    // Duty ramp: updates only on period boundaries, except an immediate stop for target 0
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            ramp_cnt_r <= '0;
            cur_duty_r <= 7'd0;
        end else if (target_s == 7'd0) begin
            ramp_cnt_r <= '0;
            cur_duty_r <= 7'd0;
        end else if (boundary_s) begin
            if (ramp_cnt_r == RAMP_W'(RAMP_PERIODS - 1)) begin
                ramp_cnt_r <= '0;
                cur_duty_r <= next_duty_s;
            end else begin
                ramp_cnt_r <= ramp_cnt_r + RAMP_W'(1);
            end
        end
    end

    // Timer FSM with countdown; a press takes priority over a coincident expiry
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            btn_prev_r <= 1'b0;
            tstate_r   <= T_OFF;
            remain_r   <= 9'd0;
            expired_r  <= 1'b0;
            sec_cnt_r  <= '0;
        end else begin
            btn_prev_r <= i_timer_btn;
            if (press_s) begin
                sec_cnt_r <= '0;
                expired_r <= 1'b0;
                case (tstate_r)
                    T_OFF: begin tstate_r <= T_1;   remain_r <= 9'(T1_SEC); end
                    T_1:   begin tstate_r <= T_2;   remain_r <= 9'(T2_SEC); end
                    T_2:   begin tstate_r <= T_3;   remain_r <= 9'(T3_SEC); end
                    T_3:   begin tstate_r <= T_OFF; remain_r <= 9'd0;       end
                    default: begin tstate_r <= T_OFF; remain_r <= 9'd0;     end
                endcase
            end else if (sec_wrap_s) begin
                sec_cnt_r <= '0;
                if (remain_r <= 9'd1) begin
                    expired_r <= 1'b1;
                    tstate_r  <= T_OFF;
                    remain_r  <= 9'd0;
                end else begin
                    remain_r <= remain_r - 9'd1;
                end
            end else if (tstate_r != T_OFF) begin
                sec_cnt_r <= sec_cnt_r + SEC_W'(1);
            end else begin
                sec_cnt_r <= '0;
            end
        end
    end

    assign o_pwm           = pwm_r;
    assign o_duty          = cur_duty_r;
    assign o_timer_state   = tstate_r;
    assign o_remain_sec    = remain_r;
    assign o_timer_expired = expired_r;

endmodule

// File: tb/tb_motor_pwm_timer.sv
// Scoreboard bench for motor_pwm_timer: expected output snapshots are queued by the stimulus
// and compared by a monitor each time the DUT's duty/timer outputs change.
module tb_motor_pwm_timer;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] speed;
    logic       btn;
    logic       o_pwm;
    logic [6:0] o_duty;
    logic [1:0] o_timer_state;
    logic [8:0] o_remain_sec;
    logic       o_timer_expired;

    typedef struct packed {
        logic [6:0] duty;
        logic [1:0] tst;
        logic [8:0] rem;
        logic       exp;
    } snap_t;

    snap_t exp_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    int    cyc      = 0;
    bit    mon_en   = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    motor_pwm_timer #(
        .TICK_DIV(2), .RAMP_PERIODS(1), .RAMP_STEP(25), .SEC_CYCLES(10),
        .T1_SEC(3), .T2_SEC(5), .T3_SEC(7)
    ) dut (
        .i_clk(clk), .i_reset(rst), .i_speed_state(speed), .i_timer_btn(btn),
        .o_pwm(o_pwm), .o_duty(o_duty), .o_timer_state(o_timer_state),
        .o_remain_sec(o_remain_sec), .o_timer_expired(o_timer_expired)
    );

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    function automatic snap_t snap_now();
        return {o_duty, o_timer_state, o_remain_sec, o_timer_expired};
    endfunction

    task automatic push(input int duty, input int tst, input int rem, input int ex);
        snap_t s;
        s.duty = 7'(duty); s.tst = 2'(tst); s.rem = 9'(rem); s.exp = 1'(ex);
        exp_q.push_back(s);
    endtask

    task automatic wait_duty(input int val, input string name, output int at);
        for (int i = 0; i < 1000; i++) begin
            if (int'(o_duty) == val) break;
            @(negedge clk);
        end
        at = cyc;
        check(name, int'(o_duty), val);
    endtask

    task automatic press();
        btn = 1'b1;
        @(negedge clk);
        btn = 1'b0;
    endtask

    // Monitor: every change of the duty/timer outputs must match the next queued snapshot
    initial begin
        snap_t last, cur, e;
        wait (mon_en);
        last = snap_now();
        forever begin
            @(negedge clk);
            cur = snap_now();
            if (cur != last) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_change", int'(cur), int'(last));
                end else begin
                    e = exp_q.pop_front();
                    check("snapshot", int'(cur), int'(e));
                end
                last = cur;
            end
        end
    end

    initial begin
        int t0, t1, t2, t3, hi, lo, errs;
        int st_exp[4];
        int rm_exp[4];
        st_exp = '{1, 2, 3, 0};
        rm_exp = '{3, 5, 7, 0};
        rst = 1'b1; speed = 3'd0; btn = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", int'({o_pwm, snap_now()}), 0);
        rst = 1'b0;
        mon_en = 1'b1;

        errs = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if ({o_pwm, snap_now()} != 20'd0) errs++;
        end
        check("idle_all_zero", errs, 0);

        // Ramp 0 -> 100 in 25% steps, one per PWM period
        push(25, 0, 0, 0); push(50, 0, 0, 0); push(75, 0, 0, 0); push(100, 0, 0, 0);
        speed = 3'd4;
        wait_duty(25, "ramp_25", t0);
        wait_duty(50, "ramp_50", t1);
        check("interval_25_50", t1 - t0, 200);
        hi = 0;
        for (int i = 0; i < 200; i++) begin
            if (i > 0) @(negedge clk);
            if (o_pwm) hi++;
        end
        check("pwm_high_at_50", hi, 100);
        wait_duty(75, "ramp_75", t2);
        check("interval_50_75", t2 - t1, 200);
        wait_duty(100, "ramp_100", t3);
        check("interval_75_100", t3 - t2, 200);
        lo = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!o_pwm) lo++;
        end
        check("pwm_const_high_100", lo, 0);

        // Fast stop from 100
        push(0, 0, 0, 0);
        speed = 3'd0;
        @(negedge clk);
        check("fast_stop_duty", int'(o_duty), 0);
        @(negedge clk);
        check("fast_stop_pwm", int'(o_pwm), 0);

        // Ramp up from 0 toward 50
        push(25, 0, 0, 0); push(50, 0, 0, 0);
        speed = 3'd2;
        wait_duty(25, "rampup_25", t0);
        wait_duty(50, "rampup_50", t1);
        check("interval_rampup", t1 - t0, 200);

        // Single step down, then stays put
        push(25, 0, 0, 0);
        speed = 3'd1;
        wait_duty(25, "down_25", t0);
        repeat (400) @(negedge clk);
        check("no_overshoot", int'(o_duty), 25);

        // Invalid level 6 maps to 0
        push(0, 0, 0, 0);
        speed = 3'd6;
        @(negedge clk);
        check("level6_stop", int'(o_duty), 0);
        speed = 3'd0;
        repeat (10) @(negedge clk);

        // Single press, countdown to expiry
        push(0, 1, 3, 0); push(0, 1, 2, 0); push(0, 1, 1, 0); push(0, 0, 0, 1);
        press();
        check("press1_state", int'(o_timer_state), 1);
        check("press1_remain", int'(o_remain_sec), 3);
        repeat (29) @(negedge clk);
        check("pre_expiry_remain", int'(o_remain_sec), 1);
        @(negedge clk);
        check("expired_flag", int'(o_timer_expired), 1);
        check("expired_state", int'(o_timer_state), 0);

        // Held button counts once, even across the next expiry
        push(0, 1, 3, 0); push(0, 1, 2, 0); push(0, 1, 1, 0); push(0, 0, 0, 1);
        btn = 1'b1;
        @(negedge clk);
        check("repress_expired_clr", int'(o_timer_expired), 0);
        check("repress_remain", int'(o_remain_sec), 3);
        repeat (49) @(negedge clk);
        btn = 1'b0;
        check("held_once_state", int'(o_timer_state), 0);
        @(negedge clk);

        // Cycle through all four presets
        for (int k = 0; k < 4; k++) begin
            push(0, st_exp[k], rm_exp[k], 0);
            press();
            check("cycle_state", int'(o_timer_state), st_exp[k]);
            check("cycle_remain", int'(o_remain_sec), rm_exp[k]);
            @(negedge clk);
        end

        // Press on the same cycle as T1 expiry
        push(0, 1, 3, 0); push(0, 1, 2, 0); push(0, 1, 1, 0); push(0, 2, 5, 0);
        press();
        repeat (29) @(negedge clk);
        press();
        check("coinc_state", int'(o_timer_state), 2);
        check("coinc_remain", int'(o_remain_sec), 5);
        check("coinc_expired", int'(o_timer_expired), 0);

        // Reset during the T2 countdown
        push(0, 2, 4, 0);
        repeat (15) @(negedge clk);
        push(0, 0, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        check("reset_timer_outputs", int'({o_timer_state, o_remain_sec, o_timer_expired}), 0);
        rst = 1'b0;
        repeat (50) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
